// File: rtl/branch_trace_player.sv
// Trace-driven stimulus source and hit/miss scoreboard for branch predictors.
// Streams trace records one per cycle and realigns each prediction with its outcome.
module branch_trace_player #(
    parameter int ADDR_W   = 32,
    parameter int TRACE_AW = 10,
    parameter int PRED_LAT = 3,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TRACE_AW:0]     trace_len,
    output logic                  mem_rd_en,
    output logic [TRACE_AW-1:0]   mem_addr,
    input  logic [2*ADDR_W:0]     mem_rd_data,
    output logic                  bp_valid,
    output logic [ADDR_W-1:0]     bp_direction,
    output logic [ADDR_W-1:0]     bp_next_PC,
    output logic                  bp_branch_result,
    input  logic                  bp_prediction,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      total_branch,
    output logic [CNT_W-1:0]      correct_cnt,
    output logic [CNT_W-1:0]      mispred_cnt
);

    localparam int LW = TRACE_AW + 1;
    localparam int DW = $clog2(PRED_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       len_q, len_d;
    logic [LW-1:0]       nxt_q, nxt_d;
    logic                rd_en_q, rd_en_d;
    logic [TRACE_AW-1:0] addr_q, addr_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   last_pc_q, last_pc_d;
    logic [ADDR_W-1:0]   last_tgt_q, last_tgt_d;
    logic                last_out_q, last_out_d;
    logic [PRED_LAT-1:0] dl_v_q, dl_v_d;
    logic [PRED_LAT-1:0] dl_o_q, dl_o_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    total_q, total_d;
    logic [CNT_W-1:0]    correct_q, correct_d;
    logic [CNT_W-1:0]    mispred_q, mispred_d;

    logic [ADDR_W-1:0]   rd_pc;
    logic [ADDR_W-1:0]   rd_tgt;
    logic                rd_out;

    assign rd_pc  = mem_rd_data[ADDR_W-1:0];
    assign rd_tgt = mem_rd_data[2*ADDR_W-1:ADDR_W];
    assign rd_out = mem_rd_data[2*ADDR_W];

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        nxt_d      = nxt_q;
        addr_d     = addr_q;
        rd_en_d    = 1'b0;
        valid_d    = rd_en_q;
        last_pc_d  = last_pc_q;
        last_tgt_d = last_tgt_q;
        last_out_d = last_out_q;
        drain_d    = drain_q;
        total_d    = total_q;
        correct_d  = correct_q;
        mispred_d  = mispred_q;
        dl_v_d     = dl_v_q;
        dl_o_d     = dl_o_q;

        dl_v_d[0] = valid_q;
        dl_o_d[0] = bp_branch_result;
        for (int i = 1; i < PRED_LAT; i++) begin
            dl_v_d[i] = dl_v_q[i-1];
            dl_o_d[i] = dl_o_q[i-1];
        end

        if (rd_en_q && (nxt_q < len_q)) begin
            rd_en_d = 1'b1;
            addr_d  = nxt_q[TRACE_AW-1:0];
            nxt_d   = nxt_q + LW'(1);
        end

        if (valid_q) begin
            last_pc_d  = rd_pc;
            last_tgt_d = rd_tgt;
            last_out_d = rd_out;
        end

        // All three counters freeze together so total == correct + mispred holds
        if (dl_v_q[PRED_LAT-1] && !(&total_q)) begin
            total_d = total_q + CNT_W'(1);
            if (bp_prediction == dl_o_q[PRED_LAT-1])
                correct_d = correct_q + CNT_W'(1);
            else
                mispred_d = mispred_q + CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    total_d   = '0;
                    correct_d = '0;
                    mispred_d = '0;
                    len_d     = trace_len;
                    if (trace_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        rd_en_d = 1'b1;
                        addr_d  = '0;
                        nxt_d   = LW'(1);
                    end
                end
            end
            S_FETCH:  state_d = S_STREAM;
            S_STREAM: begin
                if (valid_q && !rd_en_q) begin
                    state_d = S_DRAIN;
                    drain_d = DW'(PRED_LAT - 1);
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) state_d = S_DONE;
                else drain_d = drain_q - DW'(1);
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            rd_en_d = 1'b0;
            valid_d = 1'b0;
            dl_v_d  = '0;
            dl_o_d  = '0;
        end

        busy_d = (state_d == S_FETCH) || (state_d == S_STREAM)
              || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            nxt_q      <= '0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            last_pc_q  <= '0;
            last_tgt_q <= '0;
            last_out_q <= 1'b0;
            dl_v_q     <= '0;
            dl_o_q     <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            total_q    <= '0;
            correct_q  <= '0;
            mispred_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            nxt_q      <= nxt_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            last_pc_q  <= last_pc_d;
            last_tgt_q <= last_tgt_d;
            last_out_q <= last_out_d;
            dl_v_q     <= dl_v_d;
            dl_o_q     <= dl_o_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            total_q    <= total_d;
            correct_q  <= correct_d;
            mispred_q  <= mispred_d;
        end
    end

    // Presented fields come straight from the memory word; they hold when idle
    assign bp_valid         = valid_q;
    assign bp_direction     = valid_q ? rd_pc  : last_pc_q;
    assign bp_next_PC       = valid_q ? rd_tgt : last_tgt_q;
    assign bp_branch_result = valid_q ? rd_out : last_out_q;
    assign mem_rd_en        = rd_en_q;
    assign mem_addr         = addr_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign total_branch     = total_q;
    assign correct_cnt      = correct_q;
    assign mispred_cnt      = mispred_q;

endmodule
